// File: rtl/button_scan_ctrl.sv
// button_scan_ctrl: four-button debouncer sharing one 16-bit settle timer.
// Each raw input is synchronized, then a round-robin FSM (IDLE/SETTLE/COMMIT)
// lends the single counter to one button whose synchronized level differs
// from its debounced level. A button must hold its new level for
// DEBOUNCE_CYCLES consecutive cycles before the change is accepted. Then
// btn_stable flips and a one-cycle press or release pulse is emitted.
// Optional feature: define BUTTON_TOGGLE_OUT_EN to add led_out. Each led_out
// bit is a toggle that flips on every accepted press of its button.
module button_scan_ctrl #(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] btn_in,
    output logic [3:0] btn_stable,
    output logic [3:0] press_pulse,
    output logic [3:0] release_pulse,
    output logic       busy,
    output logic [1:0] active_id
`ifdef BUTTON_TOGGLE_OUT_EN
    ,
    output logic [3:0] led_out
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        COMMIT = 2'd2
    } state_t;

    localparam logic [15:0] CNT_LAST = DEBOUNCE_CYCLES - 16'd1;

    state_t      state, state_next;
    logic [3:0]  sync_meta, sync;
    logic [1:0]  ptr, ptr_next;
    logic [1:0]  sel, sel_next;
    logic [15:0] cnt, cnt_next;
    logic [1:0]  idx;
    logic        found;

    // The owner index doubles as the reported active_id. It is only loaded
    // when a session starts, so it holds the last owner while idle.
    assign active_id = sel;
    assign busy      = (state != IDLE);

    // Two-flop synchronizer for the raw, asynchronous button levels.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
        if (reset) begin
            sync_meta <= 4'b0000;
            sync      <= 4'b0000;
        end else begin
            sync_meta <= btn_in;
            sync      <= sync_meta;
        end
    end

    // FSM state register together with the timer, pointer and owner registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            ptr   <= 2'd0;
            sel   <= 2'd0;
            cnt   <= 16'd0;
        end else begin
            state <= state_next;
            ptr   <= ptr_next;
            sel   <= sel_next;
            cnt   <= cnt_next;
        end
    end

    // Next-state logic: round-robin scan in IDLE, timing in SETTLE, one-cycle COMMIT.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_next = state;
        ptr_next   = ptr;
        sel_next   = sel;
        cnt_next   = cnt;
        idx        = ptr;
        found      = 1'b0;
        unique case (state)
            IDLE: begin
                // The first mismatch in the order ptr, ptr+1, ptr+2, ptr+3 wins.
                for (int off = 0; off < 4; off++) begin
                    idx = ptr + 2'(off);
                    if (!found && (sync[idx] != btn_stable[idx])) begin
                        found    = 1'b1;
                        sel_next = idx;
                    end
                end
                if (found) begin
                    cnt_next   = 16'd0;
                    state_next = SETTLE;
                end
            end
            SETTLE: begin
                if (sync[sel] == btn_stable[sel]) begin
                    // The input bounced back: give up the timer and move the scan on.
                    state_next = IDLE;
                    ptr_next   = sel + 2'd1;
                end else if (cnt == CNT_LAST) begin
                    state_next = COMMIT;
                end else begin
                    cnt_next = cnt + 16'd1;
                end
            end
            COMMIT: begin
                state_next = IDLE;
                ptr_next   = sel + 2'd1;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Output registers: flip the owner's debounced level and pulse on the edge ending COMMIT.
    always_ff @(posedge clk) begin
        if (reset) begin
            btn_stable    <= 4'b0000;
            press_pulse   <= 4'b0000;
            release_pulse <= 4'b0000;
        end else begin
            press_pulse   <= 4'b0000;
            release_pulse <= 4'b0000;
            if (state == COMMIT) begin
                btn_stable[sel] <= ~btn_stable[sel];
                if (btn_stable[sel]) begin
                    release_pulse[sel] <= 1'b1;
                end else begin
                    press_pulse[sel] <= 1'b1;
                end
            end
        end
    end

`ifdef BUTTON_TOGGLE_OUT_EN
    // Toggle outputs: a bit flips on the same edge that raises its press pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            led_out <= 4'b0000;
        end else if ((state == COMMIT) && !btn_stable[sel]) begin
            led_out[sel] <= ~led_out[sel];
        end
    end
`endif

endmodule

// File: doc/button_scan_ctrl.md
BUTTON_SCAN_CTRL -- requirements
Module: button_scan_ctrl

Interface
REQ-001: Parameter DEBOUNCE_CYCLES, default 16'd50000, is the number of consecutive stable clock cycles needed to accept a change; legal range 1..65535.
REQ-002: clk  input  1  single system clock; all logic is on its rising edge.
REQ-003: reset  input  1  synchronous, active-high reset.
REQ-004: btn_in  input  4  raw asynchronous button levels, 1 = pressed.
REQ-005: btn_stable  output  4  debounced button levels.
REQ-006: press_pulse  output  4  one-cycle pulse per bit when that button's stable level rises.
REQ-007: release_pulse  output  4  one-cycle pulse per bit when that button's stable level falls.
REQ-008: busy  output  1  high while the shared debounce timer is allocated (SETTLE or COMMIT).
REQ-009: active_id  output  2  index of the button that owns the timer; holds the last owner when idle.

Function
REQ-010: Each btn_in bit SHALL pass through a 2-flop synchronizer; only the synchronized level (sync) feeds the logic.
REQ-011: One 16-bit debounce counter SHALL be shared by all four buttons and allocated round-robin by an FSM with states IDLE, SETTLE and COMMIT.
REQ-012: IDLE: search for sync[i] != btn_stable[i], starting at pointer ptr, in order ptr, ptr+1, ptr+2, ptr+3 mod 4.
  - Match found: set sel=i, cnt=0, active_id=i; go to SETTLE.
  - No match: stay in IDLE.
REQ-013: SETTLE, sync[sel] != btn_stable[sel]:
  - cnt == DEBOUNCE_CYCLES-1: go to COMMIT.
  - Otherwise: cnt increments.
  - SETTLE therefore lasts exactly DEBOUNCE_CYCLES cycles.
REQ-014: SETTLE, sync[sel] == btn_stable[sel] (bounce): abandon without changing btn_stable; go to IDLE; ptr = sel+1 mod 4.
REQ-015: COMMIT (one cycle): on the edge ending COMMIT, btn_stable[sel] inverts; go to IDLE; ptr = sel+1 mod 4.
REQ-016: press_pulse[sel] (new level 1) or release_pulse[sel] (new level 0) SHALL be high for exactly the one cycle after COMMIT; all other pulse bits are 0.
REQ-017: Latency: when btn_in changes before edge k and stays stable, btn_stable and the pulse SHALL become visible after edge k+DEBOUNCE_CYCLES+3.
REQ-018: Buttons not owning the timer SHALL wait; their pending changes are found in later IDLE scans.
REQ-019: No button SHALL wait more than 3 other debounce sessions.
REQ-020: At most one btn_stable bit SHALL change per cycle.
REQ-021: At most one pulse bit in total SHALL be high per cycle.
REQ-022: cnt SHALL never wrap; it is bounded by DEBOUNCE_CYCLES-1.
REQ-023: Simultaneous changes on several buttons SHALL be served in round-robin order from ptr.
REQ-024: A button that settles back before being served SHALL generate no pulse.
REQ-025: busy = (state != IDLE), registered with the state.

Reset
REQ-026: While reset is high at a clk edge, the block SHALL set:
  - synchronizers, btn_stable, press_pulse and release_pulse to 0
  - ptr, sel, active_id and cnt to 0
  - state to IDLE and busy to 0
REQ-027: Reset asserted mid-SETTLE or mid-COMMIT SHALL abort the session with no pulse.
REQ-028: After reset, any button held pressed SHALL be debounced afresh and SHALL produce press_pulse.

Configuration
REQ-029: With macro BUTTON_TOGGLE_OUT_EN defined, the block SHALL add output led_out (4 bits, reset 0).
  - led_out[i] inverts on the same edge that raises press_pulse[i].
REQ-030: Without BUTTON_TOGGLE_OUT_EN, led_out and its registers SHALL be absent; all other behaviour is identical.

Verification (DEBOUNCE_CYCLES=8)
REQ-031: btn_in=4'b0001 steady from edge 10 -> btn_stable[0]=1 and press_pulse[0]=1 after edge 21 only, for one cycle; busy high from edge 12 through edge 20.
REQ-032: btn_in[2] toggles every 3 cycles for 40 cycles, then holds 0 -> no pulse, btn_stable=0, busy falls within 1 cycle of each bounce.
REQ-033: btn_in=4'b1111 at once, ptr=0 -> press_pulse order bits 0,1,2,3; pulses 10 cycles apart; the last after edge k+41.
REQ-034: reset at cycle 5 of SETTLE for button 1 -> no pulse; all outputs 0 next cycle; button still held -> press_pulse[1] DEBOUNCE_CYCLES+3 edges after reset release.
REQ-035: Press then release button 3, each held 20 cycles -> one press_pulse[3], then one release_pulse[3]; with BUTTON_TOGGLE_OUT_EN, led_out[3] 0->1 and stays 1.
REQ-036: Button 0 released during button 2's SETTLE -> button 2 commits first, then button 0 is served with ptr=3 order; no lost or duplicate pulses.
